// File: rtl/spi_target_if.sv
// SoC-side byte interface of the SPI responder.
//   master modport: SoC logic (drives tx_data/tx_valid/rx_ack, observes the rest)
//   slave modport : spi_target (drives tx_ready/rx_data/rx_valid/overrun/underrun/busy)
//   tx_data/tx_valid/tx_ready : valid/ready transmit byte handoff
//   rx_data/rx_valid/rx_ack   : received byte, held until acknowledged
//   overrun/underrun          : sticky error flags
//   busy                      : synchronized chip select asserted
interface spi_target_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       overrun;
  logic       underrun;
  logic       busy;

  modport master (
    output tx_data, tx_valid, rx_ack,
    input  tx_ready, rx_data, rx_valid, overrun, underrun, busy
  );

  modport slave (
    input  tx_data, tx_valid, rx_ack,
    output tx_ready, rx_data, rx_valid, overrun, underrun, busy
  );
endinterface

// File: rtl/spi_target.sv
// SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first. The external SPI pins are
// oversampled in the clk domain; one byte is shifted in per 8 sclk cycles and a
// byte from a one-deep transmit holding register is shifted out.
//   clk, rst_n : system clock, synchronous active-low reset
//   sclk, cs_n, mosi : external SPI pins (asynchronous to clk)
//   miso : responder data out (registered)
//   soc  : SoC-side byte interface (spi_target_if.slave)
//
// state  | meaning
// IDLE   | synced cs_n high; miso parked at 1, bit counter cleared
// ACTIVE | synced cs_n low; shifting bytes on synced sclk edges
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sclk,
  input  logic           cs_n,
  input  logic           mosi,
  output logic           miso,
  spi_target_if.slave    soc
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [7:0] rx_shift, rx_shift_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] tx_hold, tx_hold_nxt;
  logic       tx_full, tx_full_nxt;
  logic [7:0] rx_data_q, rx_data_nxt;
  logic       rx_valid_q, rx_valid_nxt;
  logic       overrun_q, overrun_nxt;
  logic       underrun_q, underrun_nxt;
  logic       tx_ready_q;
  logic       miso_q, miso_nxt;
  logic       busy_q, busy_nxt;
  logic       accept, load, byte_done;

  // Pin synchronizers plus one extra stage on sclk/cs_n for edge detection.
  // Reset values match the idle levels of the pins so reset creates no edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // tx_ready_q always equals !tx_full, so accept only happens into an empty register.
  assign accept = soc.tx_valid & tx_ready_q;

  always_comb begin
    state_nxt    = state;
    rx_shift_nxt = rx_shift;
    tx_shift_nxt = tx_shift;
    bit_cnt_nxt  = bit_cnt;
    rx_data_nxt  = rx_data_q;
    byte_done    = 1'b0;
    load         = 1'b0;

    case (state)
      IDLE: begin
        bit_cnt_nxt = 3'd0;
        if (cs_fall) begin
          state_nxt = ACTIVE;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Abort: anything partially shifted is dropped, including a tx byte
          // already taken from the holding register.
          state_nxt    = IDLE;
          rx_shift_nxt = '0;
          tx_shift_nxt = '0;
          bit_cnt_nxt  = 3'd0;
        end else if (sclk_rise) begin
          rx_shift_nxt = {rx_shift[6:0], mosi_s};
          bit_cnt_nxt  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done   = 1'b1;
            rx_data_nxt = {rx_shift[6:0], mosi_s};
          end
        end else if (sclk_fall) begin
          // bit_cnt==0 on a fall means the previous byte just finished.
          if (bit_cnt == 3'd0) load = 1'b1;
          else                 tx_shift_nxt = {tx_shift[6:0], 1'b0};
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) tx_shift_nxt = tx_full ? tx_hold : IDLE_BYTE;

    // A load from an empty register and an accept in the same cycle: the
    // accepted byte stays put for the next slot.
    tx_hold_nxt  = accept ? soc.tx_data : tx_hold;
    tx_full_nxt  = accept ? 1'b1 : (load ? 1'b0 : tx_full);

    // Sticky flags: set takes priority over a same-cycle clear.
    underrun_nxt = (load & ~tx_full) | (underrun_q & ~accept);
    rx_valid_nxt = byte_done | (rx_valid_q & ~soc.rx_ack);
    overrun_nxt  = (byte_done & rx_valid_q & ~soc.rx_ack) | (overrun_q & ~soc.rx_ack);

    miso_nxt     = (state_nxt == ACTIVE) ? tx_shift_nxt[7] : 1'b1;
    busy_nxt     = (state_nxt == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shift   <= '0;
      tx_shift   <= '0;
      bit_cnt    <= 3'd0;
      tx_hold    <= '0;
      tx_full    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      tx_ready_q <= 1'b1;
      miso_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      rx_shift   <= rx_shift_nxt;
      tx_shift   <= tx_shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      tx_hold    <= tx_hold_nxt;
      tx_full    <= tx_full_nxt;
      rx_data_q  <= rx_data_nxt;
      rx_valid_q <= rx_valid_nxt;
      overrun_q  <= overrun_nxt;
      underrun_q <= underrun_nxt;
      tx_ready_q <= ~tx_full_nxt;
      miso_q     <= miso_nxt;
      busy_q     <= busy_nxt;
    end
  end

  assign miso         = miso_q;
  assign soc.tx_ready = tx_ready_q;
  assign soc.rx_data  = rx_data_q;
  assign soc.rx_valid = rx_valid_q;
  assign soc.overrun  = overrun_q;
  assign soc.underrun = underrun_q;
  assign soc.busy     = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI master model drives sclk/cs_n/mosi at
// clk/16, and scoreboard queues hold the bytes expected on miso and rx_data.
module tb_spi_target;
  localparam int SYNC = 2;
  localparam int H    = 8;   // sclk half period in clk cycles

  logic clk = 1'b0;
  logic rst_n, sclk, cs_n, mosi, miso;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_miso[$];
  logic [7:0] exp_rx[$];
  logic [7:0] mi, e;

  spi_target_if soc_if ();

  spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (sclk),
    .cs_n  (cs_n),
    .mosi  (mosi),
    .miso  (miso),
    .soc   (soc_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (soc_if.tx_ready !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    if (soc_if.tx_ready !== 1'b1) chk("tx_ready_timeout", soc_if.tx_ready, 1);
  endtask

  task automatic push_tx(input logic [7:0] b);
    wait_ready();
    soc_if.tx_data  = b;
    soc_if.tx_valid = 1'b1;
    exp_miso.push_back(b);
    tick(1);
    soc_if.tx_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    soc_if.rx_ack = 1'b1;
    tick(1);
    soc_if.rx_ack = 1'b0;
  endtask

  // Shifts nbits of mo; miso is sampled just before each rising sclk edge.
  // On a full byte, rx_data/rx_valid are checked SYNC+1 clocks after the 8th
  // rise; ack_done pulses rx_ack on exactly the completion cycle; last raises
  // cs_n before the final sclk fall so no further load happens.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit last,
                          input bit ack_done, output logic [7:0] mi_o);
    mi_o = 8'h00;
    if (nbits == 8) exp_rx.push_back(mo);
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[3'(7 - i)];
      tick(H);
      mi_o[3'(7 - i)] = miso;
      sclk = 1'b1;
      if (i == 7) begin
        if (ack_done) begin
          tick(SYNC);
          soc_if.rx_ack = 1'b1;
          tick(1);
          soc_if.rx_ack = 1'b0;
        end else begin
          tick(SYNC + 1);
        end
        chk("rx_valid_latency", soc_if.rx_valid, 1);
        chk("rx_data", soc_if.rx_data, exp_rx.pop_front());
        if (last) begin
          tick(1);
          cs_n = 1'b1;
          tick(H - SYNC - 2);
        end else begin
          tick(H - SYNC - 1);
        end
      end else begin
        tick(H);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] mo, input bit last, input bit ack_done);
    logic [7:0] got;
    spi_bits(mo, 8, last, ack_done, got);
    chk("miso_byte", got, exp_miso.pop_front());
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b1;
    soc_if.tx_data = 8'h00; soc_if.tx_valid = 1'b0; soc_if.rx_ack = 1'b0;

    // Reset values
    tick(3);
    chk("rst_miso", miso, 1);
    chk("rst_tx_ready", soc_if.tx_ready, 1);
    chk("rst_rx_valid", soc_if.rx_valid, 0);
    chk("rst_rx_data", soc_if.rx_data, 8'h00);
    chk("rst_busy", soc_if.busy, 0);
    chk("rst_overrun", soc_if.overrun, 0);
    chk("rst_underrun", soc_if.underrun, 0);
    rst_n = 1'b1;
    tick(2);

    // Single byte
    push_tx(8'hA5);
    chk("single_tx_ready_full", soc_if.tx_ready, 0);
    cs_n = 1'b0;
    tick(H);
    chk("single_busy", soc_if.busy, 1);
    xfer(8'h3C, 1, 0);
    tick(H);
    chk("single_underrun", soc_if.underrun, 0);
    chk("single_busy_end", soc_if.busy, 0);
    chk("single_miso_idle", miso, 1);
    pulse_ack();
    chk("single_ack", soc_if.rx_valid, 0);

    // Back-to-back frame with refills
    push_tx(8'hA5);
    cs_n = 1'b0;
    tick(H);
    push_tx(8'h81);
    xfer(8'h11, 0, 0);
    pulse_ack();
    push_tx(8'h42);
    xfer(8'h22, 0, 0);
    pulse_ack();
    xfer(8'h33, 1, 0);
    pulse_ack();
    tick(H);
    chk("b2b_overrun", soc_if.overrun, 0);
    chk("b2b_underrun", soc_if.underrun, 0);
    chk("b2b_rx_valid", soc_if.rx_valid, 0);

    // Abort after 5 bits
    push_tx(8'h5A);
    cs_n = 1'b0;
    tick(H);
    spi_bits(8'hF0, 5, 0, 0, mi);
    tick(H);
    cs_n = 1'b1;
    tick(H);
    e = exp_miso.pop_front();
    chk("abort_miso_bits", mi[7:3], e[7:3]);
    chk("abort_rx_valid", soc_if.rx_valid, 0);
    chk("abort_miso_idle", miso, 1);
    chk("abort_busy", soc_if.busy, 0);
    push_tx(8'h96);
    cs_n = 1'b0;
    tick(H);
    xfer(8'h0F, 1, 0);
    pulse_ack();
    tick(H);

    // Underrun and overrun
    cs_n = 1'b0;
    exp_miso.push_back(8'hFF);
    exp_miso.push_back(8'hFF);
    tick(H);
    xfer(8'h01, 0, 0);
    xfer(8'h02, 1, 0);
    tick(H);
    chk("ovr_underrun", soc_if.underrun, 1);
    chk("ovr_overrun", soc_if.overrun, 1);
    chk("ovr_rx_data", soc_if.rx_data, 8'h02);
    pulse_ack();
    chk("ovr_ack_rx_valid", soc_if.rx_valid, 0);
    chk("ovr_ack_overrun", soc_if.overrun, 0);
    chk("ovr_underrun_kept", soc_if.underrun, 1);

    // rx_ack on the completion cycle
    push_tx(8'hE7);
    chk("accept_clears_underrun", soc_if.underrun, 0);
    cs_n = 1'b0;
    tick(H);
    xfer(8'h55, 0, 0);
    exp_miso.push_back(8'hFF);
    xfer(8'hAA, 1, 1);
    tick(H);
    chk("simack_overrun", soc_if.overrun, 0);
    chk("simack_rx_valid", soc_if.rx_valid, 1);
    chk("simack_rx_data", soc_if.rx_data, 8'hAA);
    pulse_ack();

    // tx accept in the same cycle as an empty load at cs_n fall
    cs_n = 1'b0;
    tick(SYNC);
    soc_if.tx_data  = 8'hC3;
    soc_if.tx_valid = 1'b1;
    tick(1);
    soc_if.tx_valid = 1'b0;
    exp_miso.push_back(8'hFF);
    exp_miso.push_back(8'hC3);
    tick(H - SYNC - 1);
    xfer(8'h00, 0, 0);
    pulse_ack();
    xfer(8'h5A, 1, 0);
    tick(H);
    chk("simacc_underrun", soc_if.underrun, 1);
    chk("simacc_tx_ready", soc_if.tx_ready, 1);

    // Reset in the middle of a byte, with rx_valid set and the holding register full
    push_tx(8'h77);
    cs_n = 1'b0;
    tick(H);
    spi_bits(8'hFF, 3, 0, 0, mi);
    e = exp_miso.pop_front();
    chk("midrst_miso_bits", mi[7:5], e[7:5]);
    push_tx(8'h88);
    void'(exp_miso.pop_front());
    rst_n = 1'b0;
    cs_n  = 1'b1;
    tick(1);
    chk("midrst_busy", soc_if.busy, 0);
    chk("midrst_miso", miso, 1);
    chk("midrst_tx_ready", soc_if.tx_ready, 1);
    chk("midrst_rx_valid", soc_if.rx_valid, 0);
    chk("midrst_rx_data", soc_if.rx_data, 8'h00);
    rst_n = 1'b1;
    tick(H);
    chk("postrst_busy", soc_if.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
